// File: rtl/vga_sync_if.sv
// Timing outputs of the VGA sync generator, grouped for the pixel/colour logic.
// Outputs change only on the clk after pix_tick and hold between ticks. There is no ready: the consumer samples them.
interface vga_sync_if #(
  parameter int CW = 10
);
  logic          pix_tick;
  logic [CW-1:0] px_x;
  logic [CW-1:0] px_y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          frame_start;

  modport master (
    output pix_tick, px_x, px_y, hsync, vsync, video_on, frame_start
  );

  modport slave (
    input pix_tick, px_x, px_y, hsync, vsync, video_on, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator on the master clock: a pixel-tick enable drives the h/v counters.
// Syncs and video_on are decoded from the next counter values, so they line up with px_x/px_y.
module vga_sync_gen #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 10
) (
  input  logic        clk,
  input  logic        rst,
  vga_sync_if.master  vga
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          pix_tick_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          video_on_r;
  logic          frame_start_r;

  logic          tick_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;

  assign tick_nxt = (div_cnt == DW'(DIV - 1));

  always_comb begin
    h_wrap = (h_cnt == CW'(H_TOTAL - 1));
    v_wrap = (v_cnt == CW'(V_TOTAL - 1));
    h_nxt  = h_wrap ? '0 : h_cnt + CW'(1);
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v_cnt + CW'(1);
    end
  end

  // Reset parks the counters on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      h_cnt         <= CW'(H_TOTAL - 1);
      v_cnt         <= CW'(V_TOTAL - 1);
      pix_tick_r    <= 1'b0;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      video_on_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      div_cnt       <= tick_nxt ? '0 : div_cnt + DW'(1);
      pix_tick_r    <= tick_nxt;
      frame_start_r <= tick_nxt && h_wrap && v_wrap;
      if (tick_nxt) begin
        h_cnt      <= h_nxt;
        v_cnt      <= v_nxt;
        hsync_r    <= !((h_nxt >= CW'(HS_START)) && (h_nxt < CW'(HS_END)));
        vsync_r    <= !((v_nxt >= CW'(VS_START)) && (v_nxt < CW'(VS_END)));
        video_on_r <= (h_nxt < CW'(H_ACTIVE)) && (v_nxt < CW'(V_ACTIVE));
      end
    end
  end

  assign vga.pix_tick    = pix_tick_r;
  assign vga.px_x        = h_cnt;
  assign vga.px_y        = v_cnt;
  assign vga.hsync       = hsync_r;
  assign vga.vsync       = vsync_r;
  assign vga.video_on    = video_on_r;
  assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a tiny-mode instance (DIV=2), both checked
// every cycle against a closed-form timing model, with random asynchronous resets.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_if #(.CW(10)) bus_a ();
  vga_sync_if #(.CW(10)) bus_b ();

  vga_sync_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (bus_a)
  );

  vga_sync_gen #(
    .DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(10)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs n master-clock edges after reset release, packed as
  // {pix_tick, x[9:0], y[9:0], hsync, vsync, video_on, frame_start}.
  function automatic logic [31:0] model(input int n, input int div,
                                        input int ha, input int hfp, input int hsw, input int hbp,
                                        input int va, input int vfp, input int vsw, input int vbp);
    int ht, vt, k, p, x, y;
    logic tick, hs, vs, von, fs;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    k  = n / div;
    if (k == 0) return {7'd0, 1'b0, 10'(ht - 1), 10'(vt - 1), 1'b1, 1'b1, 1'b0, 1'b0};
    p    = (k - 1) % (ht * vt);
    x    = p % ht;
    y    = p / ht;
    tick = (n % div) == 0;
    fs   = tick && (p == 0);
    hs   = !(x >= ha + hfp && x < ha + hfp + hsw);
    vs   = !(y >= va + vfp && y < va + vfp + vsw);
    von  = (x < ha) && (y < va);
    return {7'd0, tick, 10'(x), 10'(y), hs, vs, von, fs};
  endfunction

  function automatic logic [31:0] model_a(input int n);
    return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [31:0] model_b(input int n);
    return model(n, 2, 8, 1, 2, 1, 4, 1, 1, 1);
  endfunction

  function automatic logic [31:0] obs_a();
    return {7'd0, bus_a.pix_tick, bus_a.px_x, bus_a.px_y, bus_a.hsync, bus_a.vsync,
            bus_a.video_on, bus_a.frame_start};
  endfunction

  function automatic logic [31:0] obs_b();
    return {7'd0, bus_b.pix_tick, bus_b.px_x, bus_b.px_y, bus_b.hsync, bus_b.vsync,
            bus_b.video_on, bus_b.frame_start};
  endfunction

  // Full-size mode: line timing, then an asynchronous reset in the middle of hsync.
  task automatic run_a();
    int n = 0;
    int hs_low = 0;
    int line_starts[$];
    bit hit = 0;
    logic [31:0] e;
    rst_a = 1'b0;
    for (int i = 0; i < 6600; i++) begin
      @(negedge clk);
      n++;
      check("a_outs", obs_a(), model_a(n));
      if (bus_a.px_y == 10'd0 && !bus_a.hsync) hs_low++;
      if (bus_a.pix_tick && bus_a.px_x == 10'd0) line_starts.push_back(n);
    end
    check("a_first_tick", line_starts[0], 4);
    check("a_hsync_low_clks", hs_low, 384);
    check("a_line_period", line_starts[1] - line_starts[0], 3200);
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      n++;
      e = model_a(n);
      check("a_outs", obs_a(), e);
      hit = (e[23:14] == 10'd700);
    end
    check("a_find_x700", 32'(hit), 32'd1);
    check("a_hsync_before_rst", 32'(bus_a.hsync), 32'd0);
    #2 rst_a = 1'b1;
    #1 check("a_async_rst", obs_a(), model_a(0));
    @(negedge clk);
    check("a_rst_hold", obs_a(), model_a(0));
    #1 rst_a = 1'b0;
    n = 0;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      n++;
      check("a_outs_restart", obs_a(), model_a(n));
    end
  endtask

  // Tiny mode: random-length runs broken by resets asserted at random points between edges.
  task automatic run_b();
    int n;
    int last_fs;
    int len;
    for (int seg = 0; seg < 8; seg++) begin
      #($urandom_range(1, 3)) rst_b = 1'b0;
      n = 0;
      last_fs = -1;
      len = $urandom_range(40, 500);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        n++;
        check("b_outs", obs_b(), model_b(n));
        if (bus_b.frame_start) begin
          if (last_fs < 0) check("b_first_fs", n, 2);
          else check("b_frame_period", n - last_fs, 168);
          last_fs = n;
        end
      end
      #($urandom_range(1, 3)) rst_b = 1'b1;
      #1 check("b_async_rst", obs_b(), model_b(0));
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        check("b_rst_hold", obs_b(), model_b(0));
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check("a_reset", obs_a(), model_a(0));
    check("b_reset", obs_b(), model_b(0));
    #1;
    fork
      run_a();
      run_b();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumer side of the 100 MHz → 25 MHz pixel-rate division.
- Runs entirely on the 100 MHz master clock. Derives a one-cycle pixel-tick enable instead of a divided clock.
- Generates 640x480@60 VGA horizontal/vertical counters, sync pulses, an active-video flag and a frame-start pulse.
- Feeds the Nim game's pixel/colour logic and the VGA connector.

Parameters:
- DIV, 4, master clocks per pixel (power of two not required, ≥2)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  master clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- pix_tick  out  1  one-clk pulse every DIV clks; all other outputs change only in the clk after a tick
- px_x  out  CW  current horizontal count, 0..H_TOTAL-1
- px_y  out  CW  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high when px_x<H_ACTIVE and px_y<V_ACTIVE
- frame_start  out  1  one-clk pulse coincident with counters entering (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525
- Prescaler:
  - Counter div_cnt runs 0..DIV-1, increments every clk and wraps to 0.
  - pix_tick is registered: high for exactly the one clk in which div_cnt has just wrapped to 0.
  - Period is DIV clks; duty is 1/DIV.
- Horizontal counter: on each tick, h_cnt increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only on a tick where h_cnt wraps; at V_TOTAL-1 (with h wrap) it wraps to 0.
- Output timing:
  - All outputs are registered and updated in the same edge as the counters.
  - px_x/px_y always equal h_cnt/v_cnt.
  - hsync, vsync and video_on always correspond to the px_x/px_y presented in the same cycle (zero skew between coordinates and syncs).
- Sync decode:
  - hsync=0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync=0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- frame_start: high for one clk, in the cycle where counters become (0,0), i.e. the clk after the tick edge that wrapped both.
- Reset (async assert, sync release by clk edge):
  - div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 (px_x=799, px_y=524).
  - hsync=1, vsync=1, video_on=0, pix_tick=0, frame_start=0.
  - The first tick after reset release moves the counters to (0,0) and fires frame_start, so every frame, including the first, starts cleanly.
  - First tick occurs DIV clks after release.
- Reset mid-frame: outputs return to reset values immediately, without waiting for clk; no partial sync pulse may be extended.
- Between ticks, all counters and outputs hold.
- No input other than clk/rst; the block free-runs.

Test Plan:
- Reset release → pix_tick first high 4 clks after release, then every 4 clks; px_x=0, px_y=0, frame_start=1 for exactly that cycle; video_on=1, hsync=1, vsync=1.
- Horizontal timing over one line:
  - hsync low for exactly 384 clks (96 ticks), starting when px_x=656 and ending when px_x=752.
  - Line period 3200 clks.
  - video_on low from px_x=640 to 799.
- Vertical timing:
  - vsync low exactly while px_y ∈ {490,491} (6400 clks).
  - video_on never high for px_y ≥ 480.
  - px_y wraps 524→0 together with px_x 799→0.
- Frame period: successive frame_start pulses exactly 1,680,000 clks apart (800×525×4); no other frame_start pulses in between.
- Assert rst asynchronously mid-hsync (px_x=700, px_y=100) between clk edges → hsync goes 1 and px_x/px_y go 799/524 before the next edge; after release, normal sequence restarts at (0,0).
- Parameter override DIV=2, H/V set to a small test mode (e.g. 8/1/2/1 and 4/1/1/1) → tick every 2 clks; line 12 ticks; frame 7 lines; sync windows at h 9..10 and v 5.
